// File: rtl/st_align_buf.sv
// Store alignment buffer: lane-aligns SB/SH/SW stores and queues them in a DEPTH-entry FIFO toward memory.
// Optional define ST_MISALIGN_CHK_EN drops misaligned SH/SW stores and pulses err.
module st_align_buf #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 sel,
    input  logic [31:0]                addr,
    input  logic [31:0]                din,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_din,
    output logic [3:0]                 mem_we,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [29:0] ent_addr_q [DEPTH];
    logic [31:0] ent_din_q  [DEPTH];
    logic [3:0]  ent_we_q   [DEPTH];

    logic        accept, sel_ok, misalign, push, pop;
    logic [31:0] enc_din;
    logic [3:0]  enc_we;

    // Returns {lane-replicated data, byte enables}; invalid sel yields zero.
    function automatic logic [35:0] encode(input logic [2:0] s, input logic [1:0] a,
                                           input logic [31:0] d);
        logic [35:0] r;
        r = '0;
        case (s)
            3'd0:    r = {{4{d[7:0]}}, 4'b0001 << a};
            3'd1:    r = {{2{d[15:0]}}, (a[1] ? 4'b1100 : 4'b0011)};
            3'd2:    r = {d, 4'b1111};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        accept            = in_valid && in_ready;
        sel_ok            = (sel < 3'd3);
        {enc_din, enc_we} = encode(sel, addr[1:0], din);
`ifdef ST_MISALIGN_CHK_EN
        misalign = ((sel == 3'd1) && addr[0]) || ((sel == 3'd2) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        push = accept && sel_ok && !misalign;
        pop  = mem_valid && mem_ready;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage holds data only; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= addr[31:2];
            ent_din_q[wr_ptr_q]  <= enc_din;
            ent_we_q[wr_ptr_q]   <= enc_we;
        end
    end

`ifdef ST_MISALIGN_CHK_EN
    logic err_q, err_d;

    always_comb err_d = accept && sel_ok && misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Outputs come only from flops, gated to zero while empty (and therefore during reset).
    assign in_ready  = (count_q < DEPTH_C);
    assign mem_valid = (count_q != '0);
    assign mem_addr  = mem_valid ? {ent_addr_q[rd_ptr_q], 2'b00} : 32'h0;
    assign mem_din   = mem_valid ? ent_din_q[rd_ptr_q] : 32'h0;
    assign mem_we    = mem_valid ? ent_we_q[rd_ptr_q] : 4'h0;
    assign count     = count_q;

endmodule

// File: tb/tb_st_align_buf.sv
// Bench for st_align_buf: directed scenarios plus random traffic against a queue-based reference.
module tb_st_align_buf;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    sel = 3'd0;
    logic [31:0]   addr = 32'h0;
    logic [31:0]   din = 32'h0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_we;
    logic [CW-1:0] count;
    logic          err;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];

    st_align_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .addr(addr), .din(din), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Expected memory-side view of a store, straight from the store-type rules.
    function automatic ent_t ref_enc(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.a  = a & 32'hffff_fffc;
        e.d  = 32'h0;
        e.we = 4'h0;
        if (s == 3'd0) begin
            e.d  = 32'(d[7:0]) * 32'h0101_0101;
            e.we = 4'(1 << a[1:0]);
        end else if (s == 3'd1) begin
            e.d  = 32'(d[15:0]) * 32'h0001_0001;
            e.we = a[1] ? 4'hc : 4'h3;
        end else if (s == 3'd2) begin
            e.d  = d;
            e.we = 4'hf;
        end
        return e;
    endfunction

    task automatic check_head(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".mem_addr"}, mem_addr, q[0].a);
            chk({tag, ".mem_din"}, mem_din, q[0].d);
            chk({tag, ".mem_we"}, 32'(mem_we), 32'(q[0].we));
        end else begin
            chk({tag, ".mem_din0"}, mem_din, 32'h0);
            chk({tag, ".mem_we0"}, 32'(mem_we), 32'h0);
        end
    endtask

    // One clock: drive at edge+1, check the pre-edge view, update the model, check post-edge.
    task automatic cyc(input logic v, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
        logic acc, mis, ok, popm;
        ent_t e;
        in_valid = v; sel = s; addr = a; din = d; mem_ready = r;
        #3;
        check_head("pre");
        acc = v && (q.size() < DEPTH);
        mis = 1'b0;
`ifdef ST_MISALIGN_CHK_EN
        mis = ((s == 3'd1) && a[0]) || ((s == 3'd2) && (a[1:0] != 2'b00));
`endif
        ok   = (s <= 3'd2) && !mis;
        popm = (q.size() != 0) && r;
        e    = ref_enc(s, a, d);
        @(posedge clk);
        if (popm) void'(q.pop_front());
        if (acc && ok) q.push_back(e);
        #1;
        chk("post.err", 32'(err), 32'(acc && (s <= 3'd2) && mis));
        chk("post.count", 32'(count), 32'(q.size()));
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst.count", 32'(count), 32'h0);
        chk("rst.mem_valid", 32'(mem_valid), 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_din", mem_din, 32'h0);
        chk("rst.mem_we", 32'(mem_we), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.in_ready", 32'(in_ready), 32'h1);

        // Byte store to the top lane.
        cyc(1'b1, 3'd0, 32'h0000_1003, 32'habcd_ef12, 1'b0);
        chk("sb.mem_addr", mem_addr, 32'h0000_1000);
        chk("sb.mem_din", mem_din, 32'h1212_1212);
        chk("sb.mem_we", 32'(mem_we), 32'h8);
        drain();

        // Halfword then word, streaming.
        cyc(1'b1, 3'd1, 32'h0000_2002, 32'h0000_ef12, 1'b1);
        chk("sh.mem_we", 32'(mem_we), 32'hc);
        chk("sh.mem_din", mem_din, 32'hef12_ef12);
        cyc(1'b1, 3'd2, 32'h0000_2004, 32'hdead_beef, 1'b1);
        chk("sw.mem_we", 32'(mem_we), 32'hf);
        chk("sw.mem_din", mem_din, 32'hdead_beef);
        drain();

        // Fill with memory stalled, attempt a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'd2, 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0);
        chk("full.count", 32'(count), 32'h4);
        chk("full.in_ready", 32'(in_ready), 32'h0);
        cyc(1'b1, 3'd2, 32'h200, 32'h5555_5555, 1'b0);
        chk("full.fifth", 32'(count), 32'h4);
        drain();
        chk("drained.count", 32'(count), 32'h0);

        // Full buffer with both sides active.
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'd2, 32'h300 + 32'(4 * i), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i % 3), $urandom, $urandom, 1'b1);
        drain();

        // Invalid store type, then a misaligned word.
        cyc(1'b1, 3'd5, 32'h0000_4000, 32'h1234_5678, 1'b0);
        chk("sel5.count", 32'(count), 32'h0);
        chk("sel5.mem_valid", 32'(mem_valid), 32'h0);
        cyc(1'b1, 3'd2, 32'h0000_3001, 32'hcafe_f00d, 1'b0);
`ifdef ST_MISALIGN_CHK_EN
        chk("mis.err", 32'(err), 32'h1);
        chk("mis.count", 32'(count), 32'h0);
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        chk("mis.err_clear", 32'(err), 32'h0);
`else
        chk("mis.mem_addr", mem_addr, 32'h0000_3000);
        chk("mis.mem_we", 32'(mem_we), 32'hf);
`endif
        drain();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] s;
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            cyc(1'($urandom_range(0, 3) != 0), s, $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Asynchronous reset in the middle of a cycle with three entries queued.
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'd0, 32'h500 + 32'(i), 32'h0000_00a0 + 32'(i), 1'b0);
        in_valid = 1'b0;
        chk("prerst.count", 32'(count), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("midrst.count", 32'(count), 32'h0);
        chk("midrst.mem_valid", 32'(mem_valid), 32'h0);
        chk("midrst.mem_we", 32'(mem_we), 32'h0);
        q.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst.in_ready", 32'(in_ready), 32'h1);
        cyc(1'b1, 3'd1, 32'h0000_6001, 32'h0000_beef, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
